square_seq: RTL and testbench

Sequential shift-and-add squarer sitting directly upstream of the threshold cutter. It consumes one unsigned WIDTH-bit sample per start request and produces its exact 2*WIDTH-bit square. It also produces a registered flag comparing the square against a threshold. Each iteration's partial-product accumulation is performed by a 2*WIDTH-bit carry-lookahead adder built from the team's generate/propagate cell tree.

---
 rtl/square_seq.sv | 134 +++++++++++++
 tb/tb_square_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/square_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : square_seq                                                |
// | Brief    : shift-and-add squarer with a registered threshold flag    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module square_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     din,
    input  logic [2*WIDTH-1:0]   thr,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dout,
    output logic                 over
);

    localparam int c_RW  = 2 * WIDTH;
    localparam int c_CW  = $clog2(WIDTH);
    localparam int c_LVL = $clog2(c_RW);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_RW-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [c_RW-1:0] r_acc;
    logic [c_CW-1:0] r_cnt;
    logic [c_RW-1:0] r_thr;
    logic [c_RW-1:0] r_dout;
    logic            r_over;

    logic            w_accept;
    logic            w_step;
    logic            w_last;
    logic [c_RW-1:0] w_addend;
    logic [c_RW-1:0] w_g;
    logic [c_RW-1:0] w_p;
    logic [c_RW-1:0] w_hs;
    logic [c_RW-1:0] w_sum;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (start) w_state_nxt = c_S_RUN;
            c_S_RUN:  if (r_cnt == c_LAST) w_state_nxt = c_S_DONE;
            c_S_DONE: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // FSM: outputs and datapath controls
    always_comb begin
        busy     = (r_state != c_S_IDLE);
        done     = (r_state == c_S_DONE);
        w_accept = (r_state == c_S_IDLE) && start;
        w_step   = (r_state == c_S_RUN);
        w_last   = (r_state == c_S_RUN) && (r_cnt == c_LAST);
    end

    // ------------------------------------------------------------------
    // Carry-lookahead adder: Kogge-Stone prefix of generate/propagate
    // cells, carry-in 0, carry-out dropped.
    // ------------------------------------------------------------------
    assign w_addend = r_mplier[0] ? r_mcand : '0;

    always_comb begin
        w_hs = r_acc ^ w_addend;
        w_g  = r_acc & w_addend;
        w_p  = w_hs;
        for (int k = 0; k < c_LVL; k++) begin
            w_g = w_g | (w_p & (w_g << (1 << k)));
            w_p = w_p & (w_p << (1 << k));
        end
        // group generate ending at bit i is the carry into bit i+1
        w_sum = w_hs ^ (w_g << 1);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_thr    <= '0;
            r_dout   <= '0;
            r_over   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mcand  <= {{WIDTH{1'b0}}, din};
                r_mplier <= din;
                r_thr    <= thr;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (w_step) begin
                r_acc    <= w_sum;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_CW'(1);
            end
            if (w_last) begin
                r_dout <= w_sum;
                r_over <= (w_sum >= r_thr);
            end
        end
    end

    assign dout = r_dout;
    assign over = r_over;

endmodule
`default_nettype wire

// File: tb/tb_square_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_square_seq                                             |
// | Brief    : scoreboard bench for square_seq (WIDTH=16)                |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_square_seq;

    localparam int WIDTH = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] din   = '0;
    logic [31:0] thr   = '0;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic        over;

    square_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .thr   (thr),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .over  (over)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sq;
        logic        ov;
    } exp_t;

    exp_t        sb_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          m_left  = 0;
    logic [31:0] m_dout  = '0;
    logic        m_over  = 1'b0;
    logic [31:0] m_sq;
    exp_t        m_e;
    exp_t        mon_e;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: pushes the expected square at acceptance, tracks busy time
    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            sb_q.delete();
            m_dout = '0;
            m_over = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (start) begin
            m_sq   = 32'(din) * 32'(din);
            m_e.sq = m_sq;
            m_e.ov = (m_sq >= thr);
            sb_q.push_back(m_e);
            m_left = WIDTH + 1;
        end
    end

    // Per-cycle compare; results popped when the DUT raises done
    always @(negedge clk) begin
        check_val("busy", 64'(busy), 64'(m_left > 0));
        check_val("done", 64'(done), 64'(m_left == 1));
        if (done) begin
            check_val("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                mon_e  = sb_q.pop_front();
                m_dout = mon_e.sq;
                m_over = mon_e.ov;
            end
        end
        check_val("dout", 64'(dout), 64'(m_dout));
        check_val("over", 64'(over), 64'(m_over));
    end

    task automatic start_op(input logic [15:0] d, input logic [31:0] t);
        din   = d;
        thr   = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, input bit noisy, output int cyc);
        cyc = from;
        while (!done && cyc < from + 100) begin
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                din   = 16'($urandom);
                thr   = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int          lat;
    logic [15:0] rd;
    logic [31:0] rsq;
    logic [31:0] rthr;

    initial begin
        repeat (2) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_dout", 64'(dout), 64'd0);
        check_val("rst_over", 64'(over), 64'd0);
        rst_n = 1'b1;

        // equality threshold
        start_op(16'd3, 32'd9);
        wait_done(1, 1'b0, lat);
        check_val("t1_lat", 64'(lat), 64'd17);
        check_val("t1_dout", 64'(dout), 64'd9);
        check_val("t1_over", 64'(over), 64'd1);

        @(negedge clk);
        start_op(16'hFFFF, 32'hFFFF_FFFF);
        wait_done(1, 1'b0, lat);
        check_val("t2_dout", 64'(dout), 64'hFFFE_0001);
        check_val("t2_over", 64'(over), 64'd0);

        @(negedge clk);
        start_op(16'd0, 32'd0);
        wait_done(1, 1'b0, lat);
        check_val("t2b_dout", 64'(dout), 64'd0);
        check_val("t2b_over", 64'(over), 64'd1);

        // start held high, din changed after acceptance
        @(negedge clk);
        din   = 16'd1234;
        thr   = 32'd0;
        start = 1'b1;
        @(negedge clk);
        din   = 16'd7;
        lat   = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_val("t3_lat", 64'(lat), 64'd17);
        check_val("t3_dout", 64'(dout), 64'd1522756);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(19, 1'b0, lat);
        check_val("t3b_lat", 64'(lat), 64'd35);
        check_val("t3b_dout", 64'(dout), 64'd49);
        check_val("t3b_over", 64'(over), 64'd1);

        // reset in cycle 8 of an operation
        @(negedge clk);
        start_op(16'd500, 32'd0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("t4_busy", 64'(busy), 64'd0);
        check_val("t4_done", 64'(done), 64'd0);
        check_val("t4_dout", 64'(dout), 64'd0);
        check_val("t4_over", 64'(over), 64'd0);
        rst_n = 1'b1;
        start_op(16'd100, 32'd10000);
        wait_done(10, 1'b0, lat);
        check_val("t4_lat", 64'(lat), 64'd26);
        check_val("t4_new_dout", 64'(dout), 64'd10000);
        check_val("t4_new_over", 64'(over), 64'd1);

        // randomized sweep
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rd  = 16'($urandom);
            rsq = 32'(rd) * 32'(rd);
            case ($urandom_range(0, 3))
                0:       rthr = rsq;
                1:       rthr = rsq + 32'd1;
                2:       rthr = rsq - 32'd1;
                default: rthr = $urandom;
            endcase
            start_op(rd, rthr);
            wait_done(1, (i % 2) == 1, lat);
            check_val("rnd_lat", 64'(lat), 64'd17);
        end

        @(negedge clk);
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
